// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width and ALU opcode encodings.
package cpu_pkg;

    localparam int WIDTH = 32;

    localparam logic [4:1] ALU_ADD  = 4'b0000;
    localparam logic [4:1] ALU_SUB  = 4'b0001;
    localparam logic [4:1] ALU_AND  = 4'b0010;
    localparam logic [4:1] ALU_OR   = 4'b0011;
    localparam logic [4:1] ALU_XOR  = 4'b0100;
    localparam logic [4:1] ALU_NOR  = 4'b0101;
    localparam logic [4:1] ALU_SLT  = 4'b0110;
    localparam logic [4:1] ALU_SLTU = 4'b0111;
    localparam logic [4:1] ALU_SLL  = 4'b1000;
    localparam logic [4:1] ALU_SRL  = 4'b1001;
    localparam logic [4:1] ALU_SRA  = 4'b1010;
    localparam logic [4:1] ALU_LUI  = 4'b1011;

    localparam logic [1:0] SHIFT_LL = 2'd0;
    localparam logic [1:0] SHIFT_RL = 2'd1;
    localparam logic [1:0] SHIFT_RA = 2'd2;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA; amount range 0..31.
module alu_shifter
    import cpu_pkg::*;
(
    input  logic [WIDTH:1] value_i,
    input  logic [5:1]     shamt_i,
    input  logic [1:0]     kind_i,
    output logic [WIDTH:1] result_o
);

    always_comb begin
        result_o = value_i;
        unique case (kind_i)
            SHIFT_LL: result_o = value_i << shamt_i;
            SHIFT_RL: result_o = value_i >> shamt_i;
            SHIFT_RA: result_o = $signed(value_i) >>> shamt_i;
            default:  result_o = value_i;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered 32-bit EX-stage ALU: result, zero and signed-overflow flags
// appear one clock after the operands and opcode are sampled.
module alu
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [WIDTH:1] inputA,
    input  logic [WIDTH:1] inputB,
    input  logic [32:1]    aluOpCode,
    output logic [WIDTH:1] out,
    output logic           zero,
    output logic           overflow
);

    logic [4:1]     op;
    logic [WIDTH:1] sum;
    logic [WIDTH:1] diff;
    logic [WIDTH:1] shift_res;
    logic [1:0]     shift_kind;
    logic [WIDTH:1] out_d, out_q;
    logic           zero_q;
    logic           ovf_d, ovf_q;
    logic           unused_opcode_bits;

    // Only the low nibble selects the operation.
    assign op                 = aluOpCode[4:1];
    assign unused_opcode_bits = ^aluOpCode[32:5];

    assign sum  = inputA + inputB;
    assign diff = inputA - inputB;

    always_comb begin
        shift_kind = SHIFT_LL;
        if (op == ALU_SRL)      shift_kind = SHIFT_RL;
        else if (op == ALU_SRA) shift_kind = SHIFT_RA;
    end

    alu_shifter u_shifter (
        .value_i  (inputB),
        .shamt_i  (inputA[5:1]),
        .kind_i   (shift_kind),
        .result_o (shift_res)
    );

    always_comb begin
        out_d = '0;
        ovf_d = 1'b0;
        case (op)
            ALU_ADD: begin
                out_d = sum;
                ovf_d = (inputA[WIDTH] == inputB[WIDTH]) && (sum[WIDTH] != inputA[WIDTH]);
            end
            ALU_SUB: begin
                out_d = diff;
                ovf_d = (inputA[WIDTH] != inputB[WIDTH]) && (diff[WIDTH] != inputA[WIDTH]);
            end
            ALU_AND:  out_d = inputA & inputB;
            ALU_OR:   out_d = inputA | inputB;
            ALU_XOR:  out_d = inputA ^ inputB;
            ALU_NOR:  out_d = ~(inputA | inputB);
            ALU_SLT:  out_d = {{(WIDTH-1){1'b0}}, ($signed(inputA) < $signed(inputB))};
            ALU_SLTU: out_d = {{(WIDTH-1){1'b0}}, (inputA < inputB)};
            ALU_SLL, ALU_SRL, ALU_SRA: out_d = shift_res;
            ALU_LUI:  out_d = {inputB[16:1], 16'b0};
            default: begin
                out_d = '0;
                ovf_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q  <= '0;
            zero_q <= 1'b1;
            ovf_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            zero_q <= (out_d == '0);
            ovf_q  <= ovf_d;
        end
    end

    assign out      = out_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU with hand-computed results.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [32:1] inputA;
    logic [32:1] inputB;
    logic [32:1] aluOpCode;
    logic [32:1] out;
    logic        zero;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inputA    (inputA),
        .inputB    (inputB),
        .aluOpCode (aluOpCode),
        .out       (out),
        .zero      (zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Drive one vector, clock it in, and sample just after the edge.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [31:0] op);
        inputA    = a;
        inputB    = b;
        aluOpCode = op;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [31:0] e_out,
                              input logic e_zero, input logic e_ovf);
        chk({tag, ".out"},  out, e_out);
        chk({tag, ".zero"}, {31'b0, zero}, {31'b0, e_zero});
        chk({tag, ".ovf"},  {31'b0, overflow}, {31'b0, e_ovf});
    endtask

    logic [31:0] basic_exp [8] = '{32'h3, 32'hFFFF_FFFF, 32'h0, 32'h3,
                                   32'h3, 32'hFFFF_FFFC, 32'h1, 32'h1};

    initial begin
        rst_n = 1'b0;
        inputA = 32'h5; inputB = 32'h5; aluOpCode = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_all("reset", 32'h0, 1'b1, 1'b0);

        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(32'h1, 32'h2, i);
            expect_all($sformatf("basic%0d", i), basic_exp[i], basic_exp[i] == 32'h0, 1'b0);
        end

        step(32'h7FFF_FFFF, 32'h1, 32'h0);
        expect_all("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
        step(32'h8000_0000, 32'h1, 32'h1);
        expect_all("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1);
        step(32'hFFFF_FFFF, 32'h1, 32'h0);
        expect_all("add_wrap", 32'h0, 1'b1, 1'b0);
        step(32'h1, 32'h8000_0000, 32'h1);
        expect_all("sub_ovf_neg", 32'h8000_0001, 1'b0, 1'b1);

        step(32'hFFFF_FFFF, 32'h1, 32'h6);
        expect_all("slt_neg", 32'h1, 1'b0, 1'b0);
        step(32'hFFFF_FFFF, 32'h1, 32'h7);
        expect_all("sltu_big", 32'h0, 1'b1, 1'b0);

        step(32'h4, 32'h8000_0000, 32'h8);
        expect_all("sll", 32'h0, 1'b1, 1'b0);
        step(32'h4, 32'h8000_0000, 32'h9);
        expect_all("srl", 32'h0800_0000, 1'b0, 1'b0);
        step(32'h4, 32'h8000_0000, 32'hA);
        expect_all("sra_neg", 32'hF800_0000, 1'b0, 1'b0);
        step(32'h4, 32'h4000_0000, 32'hA);
        expect_all("sra_pos", 32'h0400_0000, 1'b0, 1'b0);
        step(32'h0, 32'h8000_0000, 32'h8);
        expect_all("sll0", 32'h8000_0000, 1'b0, 1'b0);
        step(32'h24, 32'h1, 32'h8);
        expect_all("sll_amt_mask", 32'h10, 1'b0, 1'b0);
        step(32'h1F, 32'h1, 32'h8);
        expect_all("sll31", 32'h8000_0000, 1'b0, 1'b0);

        step(32'h0, 32'h1234_ABCD, 32'hB);
        expect_all("lui", 32'hABCD_0000, 1'b0, 1'b0);

        step(32'h7FFF_FFFF, 32'h1, 32'hFFFF_FFF0);
        expect_all("op_upper_add", 32'h8000_0000, 1'b0, 1'b1);
        step(32'hFFFF_FFFF, 32'h1, 32'hC);
        expect_all("reserved", 32'h0, 1'b1, 1'b0);
        step(32'h7FFF_FFFF, 32'h1, 32'hF);
        expect_all("reserved_f", 32'h0, 1'b1, 1'b0);

        step(32'h1, 32'h2, 32'h0);
        expect_all("pre_rst", 32'h3, 1'b0, 1'b0);
        rst_n = 1'b0;
        step(32'h7FFF_FFFF, 32'h1, 32'h0);
        expect_all("mid_rst", 32'h0, 1'b1, 1'b0);
        rst_n = 1'b1;
        step(32'h2, 32'h3, 32'h0);
        expect_all("post_rst", 32'h5, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
